// File: rtl/demux1to8_32_if.sv
// Bus bundle for the 1-to-8 word distributor: producer side (in_*, sel, din)
// and the eight consumer slots (o_valid/o_ready, o0..o7).
interface demux1to8_32_if #(
    parameter int WIDTH = 32
);
    // Handshake: a word moves on any edge where valid and ready are both high;
    // ready may be high without valid, and valid-side data may change freely while valid is low.
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] din;
    logic [7:0]       o_valid;
    logic [7:0]       o_ready;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic [WIDTH-1:0] o4;
    logic [WIDTH-1:0] o5;
    logic [WIDTH-1:0] o6;
    logic [WIDTH-1:0] o7;

    modport master (
        output in_valid, sel, din, o_ready,
        input  in_ready, o_valid, o0, o1, o2, o3, o4, o5, o6, o7
    );

    modport slave (
        input  in_valid, sel, din, o_ready,
        output in_ready, o_valid, o0, o1, o2, o3, o4, o5, o6, o7
    );
endinterface

// File: rtl/demux1to8_32.sv
// Registered 1-to-8 distributor with one single-entry buffer per destination slot.
// Optional producer stall counter enabled by defining DEMUX_STALL_CNT_EN.
module demux1to8_32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1to8_32_if.slave      bus,
    output logic [15:0]        stall_cnt
);
    // Slot FSM state: bit i set means slot i is FULL; it is also o_valid.
    logic [7:0]       state_q;
    logic [7:0]       state_d;
    logic [7:0]       push;
    logic [7:0]       pop;
    logic             ready;
    logic [WIDTH-1:0] data_q [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 8'h00;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q & ~pop) | push;
    end

    always_comb begin
        ready = !state_q[bus.sel] || bus.o_ready[bus.sel];
        pop   = state_q & bus.o_ready;
        push  = 8'h00;
        if (bus.in_valid && ready) begin
            push = 8'h01 << bus.sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (push[i]) begin
                    data_q[i] <= bus.din;
                end
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.o_valid  = state_q;
    assign bus.o0       = data_q[0];
    assign bus.o1       = data_q[1];
    assign bus.o2       = data_q[2];
    assign bus.o3       = data_q[3];
    assign bus.o4       = data_q[4];
    assign bus.o5       = data_q[5];
    assign bus.o6       = data_q[6];
    assign bus.o7       = data_q[7];

`ifdef DEMUX_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the producer offered a word that was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (bus.in_valid && !ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_demux1to8_32.sv
// Self-checking bench for demux1to8_32: directed scenarios plus random traffic
// against a queue-based model of accepted-but-undelivered words.
module tb_demux1to8_32;
    logic        clk;
    logic        rst_n;
    logic [15:0] stall_cnt;
    int          checks;
    int          errors;

    demux1to8_32_if #(.WIDTH(32)) bus ();

    demux1to8_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every accepted word tagged with its slot, removed when consumed.
    logic [34:0] exp_q[$];
    logic [31:0] last_word [8];
    int          stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit slot_full(input int s);
        foreach (exp_q[k]) begin
            if (int'(exp_q[k][34:32]) == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] slot_head(input int s);
        foreach (exp_q[k]) begin
            if (int'(exp_q[k][34:32]) == s) return exp_q[k][31:0];
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] dut_word(input int s);
        case (s)
            0: return bus.o0;
            1: return bus.o1;
            2: return bus.o2;
            3: return bus.o3;
            4: return bus.o4;
            5: return bus.o5;
            6: return bus.o6;
            default: return bus.o7;
        endcase
    endfunction

    function automatic bit model_ready();
        return !slot_full(int'(bus.sel)) || bus.o_ready[bus.sel];
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef DEMUX_STALL_CNT_EN
        return 16'(stalls);
`else
        return 16'h0000;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) last_word[i] = 32'h0;
            stalls = 0;
        end else begin
            bit acc;
            acc = bus.in_valid && model_ready();
            if (bus.in_valid && !acc && stalls < 65535) stalls++;
            for (int i = 0; i < 8; i++) begin
                if (bus.o_ready[i] && slot_full(i)) begin
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (int'(exp_q[k][34:32]) == i) begin
                            exp_q.delete(k);
                            break;
                        end
                    end
                end
            end
            if (acc) begin
                exp_q.push_back({bus.sel, bus.din});
                last_word[bus.sel] = bus.din;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] ev;
        logic       data_ok;
        ev = 8'h00;
        data_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ev[i] = slot_full(i);
            if (dut_word(i) !== last_word[i]) data_ok = 1'b0;
            if (ev[i] && bus.o_ready[i] && bus.o_valid[i]) begin
                chk("pop_order", 64'(dut_word(i)), 64'(slot_head(i)));
            end
        end
        chk("o_valid", 64'(bus.o_valid), 64'(ev));
        chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
        chk("slot_data", 64'(data_ok), 64'(1'b1));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall()));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
        bus.in_valid = v;
        bus.sel      = s;
        bus.din      = d;
        bus.o_ready  = r;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stalls = 0;
        for (int i = 0; i < 8; i++) last_word[i] = 32'h0;
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        repeat (3) cycle();
        #1;
        chk("reset_o_valid", 64'(bus.o_valid), 64'h00);
        chk("reset_in_ready", 64'(bus.in_ready), 64'h1);
        chk("reset_o7", 64'(bus.o7), 64'h0);
        rst_n = 1'b1;
        cycle();

        // Fill every slot with consumers stalled.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'hA000_0000 | 32'(i), 8'h00);
            #1;
            chk("fill_in_ready", 64'(bus.in_ready), 64'h1);
            cycle();
        end
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("fill_o_valid", 64'(bus.o_valid), 64'hFF);
        chk("fill_o3", 64'(bus.o3), 64'hA000_0003);
        chk("fill_o7", 64'(bus.o7), 64'hA000_0007);

        // Blocking against a full slot.
        drive(1'b1, 3'd3, 32'h5555_5555, 8'h00);
        #1;
        chk("block_in_ready", 64'(bus.in_ready), 64'h0);
        repeat (5) cycle();
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("block_o3", 64'(bus.o3), 64'hA000_0003);
`ifdef DEMUX_STALL_CNT_EN
        chk("block_stall", 64'(stall_cnt), 64'd5);
`else
        chk("block_stall", 64'(stall_cnt), 64'd0);
`endif

        // Pass-through on slot 5.
        drive(1'b1, 3'd5, 32'h1111_1111, 8'h20);
        cycle();
        drive(1'b1, 3'd5, 32'h2222_2222, 8'h20);
        #1;
        chk("pass_in_ready", 64'(bus.in_ready), 64'h1);
        cycle();
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("pass_o_valid5", 64'(bus.o_valid[5]), 64'h1);
        chk("pass_o5", 64'(bus.o5), 64'h2222_2222);

        // Drain all, refill 0,2,7, then pop those while pushing slot 4.
        drive(1'b0, 3'd0, 32'h0, 8'hFF);
        cycle();
        drive(1'b1, 3'd0, 32'h0000_0100, 8'h00);
        cycle();
        drive(1'b1, 3'd2, 32'h0000_0102, 8'h00);
        cycle();
        drive(1'b1, 3'd7, 32'h0000_0107, 8'h00);
        cycle();
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 8'b1000_0101);
        cycle();
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("multipop_o_valid", 64'(bus.o_valid), 64'b0001_0000);
        chk("multipop_o4", 64'(bus.o4), 64'hDEAD_BEEF);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  8'($urandom_range(0, 255)));
            cycle();
        end

`ifdef DEMUX_STALL_CNT_EN
        drive(1'b0, 3'd6, 32'h0, 8'h00);
        cycle();
        drive(1'b1, 3'd6, 32'h6666_6666, 8'h00);
        cycle();
        repeat (70000) cycle();
        #1;
        chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
        repeat (10) cycle();
        #1;
        chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
`endif

        // Build o_valid = 8'h5A and reset asynchronously between edges.
        drive(1'b0, 3'd0, 32'h0, 8'hFF);
        cycle();
        for (int i = 0; i < 8; i++) begin
            if (8'h5A & (8'h01 << i)) begin
                drive(1'b1, 3'(i), 32'hC000_0000 | 32'(i), 8'h00);
                cycle();
            end
        end
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("pre_reset_o_valid", 64'(bus.o_valid), 64'h5A);
        chk("pre_reset_o6", 64'(bus.o6), 64'hC000_0006);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_o_valid", 64'(bus.o_valid), 64'h00);
        chk("async_o1", 64'(bus.o1), 64'h0);
        chk("async_o6", 64'(bus.o6), 64'h0);
        chk("async_stall", 64'(stall_cnt), 64'h0);
        cycle();
        rst_n = 1'b1;
        drive(1'b1, 3'd2, 32'h7777_0002, 8'h00);
        cycle();
        drive(1'b0, 3'd0, 32'h0, 8'h00);
        #1;
        chk("post_reset_o2", 64'(bus.o2), 64'h7777_0002);
        chk("post_reset_o_valid", 64'(bus.o_valid), 64'h04);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux1to8_32.md
# demux1to8_32

Registered 1-to-8 distributor for 32-bit words: an upstream producer presents one word plus a 3-bit destination select, and the block steers it into one of eight single-entry output slots, each with its own valid/ready handshake. It is the write-side counterpart of the 8-to-1 read selector in the datapath. Typical uses are fanning results from a shared functional unit back to eight consumers, or to eight register-bank write ports. Each slot buffers one word, so one stalled consumer blocks only traffic addressed to it.

## Interface
- WIDTH, 32, data width of the input word and of each output slot
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on din
- in_ready  output  1  block accepts din this cycle (combinational)
- sel  input  3  destination slot index, 0..7
- din  input  WIDTH  word to distribute
- o_valid  output  8  bit i: slot i holds a word
- o_ready  input  8  bit i: consumer i takes slot i's word this cycle
- o0..o7  output  WIDTH each  slot i data register
- stall_cnt  output  16  producer stall cycles; see Configuration

## Operation
- Each slot i is a two-state machine: EMPTY (o_valid[i]=0) or FULL (o_valid[i]=1).
- in_ready = !o_valid[sel] | o_ready[sel].
  - It depends only on the addressed slot.
  - in_ready is asserted whenever that slot can take a word, independent of in_valid.
- Push to slot i when: in_valid & in_ready & sel==i.
- Pop from slot i when: o_valid[i] & o_ready[i].
- Slot transitions per cycle:
  - EMPTY + push -> FULL; oi <= din.
  - FULL + pop, no push -> EMPTY; oi holds its last value.
  - FULL + pop + push -> stays FULL; oi <= din (back-to-back pass-through).
  - FULL, no pop -> stays FULL; oi unchanged. A push to this slot is impossible here because in_ready=0.
- Per-cycle limits:
  - At most one slot is pushed per cycle.
  - Any number of slots may pop in the same cycle.
- Handshake rules on the consumer side:
  - o_ready[i] while o_valid[i]=0 is ignored.
  - The producer may change sel or din freely while in_valid=0.
- sel is fully decoded. All 8 codes are valid, so there is no illegal state.

## Timing
- Reset (rst_n low, asynchronous, any time):
  - o_valid=8'h00, o0..o7=0, stall_cnt=0.
  - in_ready reads 1 during reset.
  - A word in flight when reset asserts is dropped.
- First rising edge after rst_n rises is a normal cycle.
- Latency from accept to output: a word accepted at edge N is visible on oi with o_valid[i]=1 immediately after edge N.
- Throughput:
  - One word per cycle sustained to any slot whose consumer holds o_ready high.
  - One word per cycle when rotating across slots.
- Ordering: words to the same slot are delivered in acceptance order, with no loss and no duplication.
- Outputs o_valid and o0..o7 are registered. in_ready is the only combinational output.

## Configuration
- DEMUX_STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every clock edge where in_valid & !in_ready.
  - The counter saturates at 16'hFFFF and never wraps.
  - It is cleared only by reset.
- DEMUX_STALL_CNT_EN undefined:
  - stall_cnt is tied to 16'h0000 and no counter register is inferred.
  - Port list and all other behaviour are identical to the defined case.

## Test plan
- Reset and fill: reset; all o_ready=0; push din=32'hA000_000i to sel=i for i=0..7, one per cycle -> in_ready=1 for all 8 pushes, o_valid=8'hFF, oi=32'hA000_000i.
- Blocking: slots full, o_ready=0, in_valid=1, sel=3 for 5 cycles -> in_ready=0, o3 unchanged; stall_cnt=5 with macro defined, 0 without.
- Pass-through: slot 5 full with 32'h1111_1111, o_ready[5]=1, push 32'h2222_2222 to sel=5 in the same cycle -> in_ready=1; next cycle o_valid[5]=1, o5=32'h2222_2222.
- Multi-pop with push: slots 0,2,7 full; o_ready=8'b1000_0101; push 32'hDEAD_BEEF to sel=4 in the same cycle -> next cycle o_valid=8'b0001_0000, o4=32'hDEAD_BEEF.
- Saturation: macro defined; hold a stall for 70000 cycles -> stall_cnt=16'hFFFF and stays there.
- Async reset mid-traffic: assert rst_n low between edges while o_valid=8'h5A -> o_valid=0 and o0..o7=0 immediately, without waiting for a clock edge.
